// File: rtl/mem_handle_responder_if.sv
// Request/response bundle between an FPU mem_handle initiator and its responder.
// The initiator drives the request; the responder drives completion and region bounds.
interface mem_handle_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) ();
    logic              avail;
    logic              r_en;
    logic              w_en;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] data_store;
    logic [DATA_W-1:0] data_load;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] region_begin;
    logic [ADDR_W-1:0] region_end;

    modport master (
        output avail, r_en, w_en, ptr, data_store,
        input  data_load, done, err, region_begin, region_end
    );

    modport slave (
        input  avail, r_en, w_en, ptr, data_store,
        output data_load, done, err, region_begin, region_end
    );
endinterface

// File: rtl/mem_handle_responder.sv
// Fixed-latency scratch memory behind one mem_handle port, with region
// bounds checking, level-held done and a host preload/config path.
module mem_handle_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_l,
    mem_handle_responder_if.slave bus,
    input  logic                 cfg_load,
    input  logic [ADDR_W-1:0]    cfg_begin,
    input  logic [ADDR_W-1:0]    cfg_end,
    input  logic                 host_we,
    input  logic [ADDR_W-1:0]    host_addr,
    input  logic [DATA_W-1:0]    host_wdata,
    output logic                 host_ready,
    output logic                 busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_ERR = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [1:0]        op_q;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] load_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W-1:0] rb_q;
    logic [ADDR_W-1:0] re_q;

    logic          legal;
    logic          finish;
    logic          commit;
    logic          host_wr;
    logic [AW-1:0] idx;
    logic [AW-1:0] host_idx;

    assign idx      = ptr_q[AW-1:0];
    assign host_idx = host_addr[AW-1:0];
    assign legal    = (rb_q <= ptr_q) && (ptr_q < re_q) && (ptr_q < DEPTH_A);
    // Completion on cnt<=1 places done right after edge E+LATENCY-1,
    // with LATENCY=1 still needing one edge in ACCESS.
    assign finish   = (state == ACCESS) && bus.avail && (cnt <= 4'd1);
    assign commit   = finish && (op_q == OP_WR) && legal;
    assign host_wr  = (state == IDLE) && host_we && (host_addr < DEPTH_A);

    assign bus.data_load    = load_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.region_begin = rb_q;
    assign bus.region_end   = re_q;
    assign host_ready       = (state == IDLE);
    assign busy             = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst_l) begin
            if (host_wr) begin
                mem[host_idx] <= host_wdata;
            end else if (commit) begin
                mem[idx] <= data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state  <= IDLE;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            load_q <= '0;
            rb_q   <= '0;
            re_q   <= DEPTH_A;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfg_load) begin
                        rb_q <= cfg_begin;
                        re_q <= cfg_end;
                    end
                    if (bus.avail && !host_we && (bus.r_en || bus.w_en)) begin
                        ptr_q  <= bus.ptr;
                        data_q <= bus.data_store;
                        cnt    <= 4'(LATENCY - 1);
                        state  <= ACCESS;
                        if (bus.r_en && bus.w_en) begin
                            op_q <= OP_ERR;
                        end else if (bus.r_en) begin
                            op_q <= OP_RD;
                        end else begin
                            op_q <= OP_WR;
                        end
                    end
                end
                ACCESS: begin
                    if (!bus.avail) begin
                        state <= IDLE;
                    end else if (finish) begin
                        state  <= HOLD;
                        done_q <= 1'b1;
                        if (!legal || op_q == OP_ERR) begin
                            load_q <= '0;
                            err_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b0;
                            if (op_q == OP_RD) begin
                                load_q <= mem[idx];
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (!bus.avail) begin
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
